// File: rtl/sram_b_fifo_pkg.sv
// Shared sizing and types for the SRAM-backed streaming FIFO.
// The macro fixes both address and data width at 8 bits.
package sram_b_fifo_pkg;
  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int DEPTH      = 256;
  localparam int OBUF_DEPTH = 2;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
endpackage

// File: rtl/sram_b_fifo_obuf.sv
// Two-entry output register FIFO that absorbs the macro's registered read data.
// Head word is registered; clear drops both entries and any same-cycle push.
module sram_b_fifo_obuf #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    cnt
);
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          pop_ok;

  assign pop_ok    = pop && (cnt != 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = head;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             tail <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind whatever remains after the pop.
          if (cnt == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/unisim_sram_b_8abits.sv
// 256x8 dual-port SRAM: port 0 write-only with bit mask, port 1 read-only with one-cycle registered read.
// Contents are not initialised; reads of unwritten addresses return whatever the array holds.
module unisim_sram_b_8abits (
  input  logic       CLK,
  input  logic       CE0,
  input  logic [7:0] A0,
  input  logic [7:0] D0,
  input  logic       WE0,
  input  logic [7:0] WEM0,
  input  logic       CE1,
  input  logic [7:0] A1,
  output logic [7:0] Q1
);
  logic [7:0] mem [256];

  always_ff @(posedge CLK) begin
    if (CE0 && WE0) begin
      mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
    end
    if (CE1) begin
      Q1 <= mem[A1];
    end
  end
endmodule

// File: rtl/sram_b_fifo_ctrl.sv
// 256-entry ready/valid FIFO built on one 256x8 SRAM macro plus a 2-entry output stage.
// Reads are issued only when the output stage has room for the returning word, so the stream never stalls.
module sram_b_fifo_ctrl #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  import sram_b_fifo_pkg::*;

  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  cnt_t       mem_cnt;
  logic       rd_pend;
  logic [1:0] buf_cnt;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ;
  logic [7:0] q1;

  assign count    = mem_cnt + cnt_t'(rd_pend) + cnt_t'(buf_cnt);
  assign empty    = (count == '0);
  assign full     = (count == cnt_t'(DEPTH));
  assign in_ready = RSTN && !full && !clear;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !clear;

  // Output-stage occupancy once this cycle's pop and the in-flight read settle.
  assign occ   = 3'(buf_cnt) + 3'(rd_pend) - 3'(pop);
  assign issue = RSTN && !clear && (mem_cnt != '0) && (occ < 3'(OBUF_DEPTH));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + cnt_t'(push) - cnt_t'(issue);
      rd_pend <= issue;
    end
  end

  unisim_sram_b_8abits u_sram (
    .CLK  (CLK),
    .CE0  (push),
    .A0   (wr_ptr),
    .D0   (in_data),
    .WE0  (push),
    .WEM0 (8'hFF),
    .CE1  (issue),
    .A1   (rd_ptr),
    .Q1   (q1)
  );

  sram_b_fifo_obuf #(.DW(DW)) u_obuf (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .clear     (clear),
    .push      (rd_pend),
    .push_data (q1),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cnt       (buf_cnt)
  );
endmodule

// File: tb/tb_sram_b_fifo_ctrl.sv
// Bench for sram_b_fifo_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_sram_b_fifo_ctrl;
  logic       CLK = 1'b0;
  logic       RSTN;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [8:0] count;
  logic       empty;
  logic       full;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       s_ready, s_valid, did_push, did_pop;
  logic [7:0] s_data, pop_word, pop_exp;
  int         pre_size;
  logic [8:0] post_count;
  logic       post_valid, post_empty, post_full;

  sram_b_fifo_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 CLK = ~CLK;

  // Macro port protection: no same-address write/read, no enables during clear.
  always @(posedge CLK) begin
    if (dut.u_sram.CE0 && dut.u_sram.CE1 && dut.u_sram.A0 == dut.u_sram.A1) begin
      errors++;
      $display("FAIL port_conflict addr %0h", dut.u_sram.A0);
    end
    if (clear && (dut.u_sram.CE0 || dut.u_sram.CE1)) begin
      errors++;
      $display("FAIL enable_in_clear ce0 %0b ce1 %0b required 0 0", dut.u_sram.CE0, dut.u_sram.CE1);
    end
  end

  // One clock of stimulus, entered and left at posedge+1; updates the queue model at the edge.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy, input logic clr);
    in_valid = iv; in_data = id; out_ready = ordy; clear = clr;
    @(negedge CLK);
    s_ready  = in_ready;
    s_valid  = out_valid;
    s_data   = out_data;
    pop_word = out_data;
    did_push = iv && in_ready;
    did_pop  = out_valid && ordy && !clr;
    pre_size = exp_q.size();
    pop_exp  = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
    @(posedge CLK);
    if (clr) exp_q.delete();
    else begin
      if (did_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (did_push) exp_q.push_back(id);
    end
    #1;
    post_count = count; post_valid = out_valid; post_empty = empty; post_full = full;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; clear = 0; in_valid = 1; in_data = 8'h42; out_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h want 00", out_data); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty %0b full %0b want 1 0", empty, full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    in_valid = 0;
    RSTN = 1'b1;
    @(negedge CLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_fall_through();
    int first = -1;
    cyc(1, 8'h11, 1, 0);
    checks++; if (post_count !== 9'd1) begin errors++; $display("FAIL ft_count_after_push got %0d want 1", post_count); end
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 8'h00, 1, 0);
      if (s_valid && first < 0) begin
        first = k;
        checks++; if (s_data !== 8'h11) begin errors++; $display("FAIL ft_data got %0h want 11", s_data); end
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL ft_latency got %0d want 3", first); end
    checks++; if (post_count !== 9'd0 || post_empty !== 1'b1) begin errors++; $display("FAIL ft_count_final got %0d want 0", post_count); end
  endtask

  task automatic test_stream();
    int first = -1, pops = 0, gaps = 0, bad = 0, maxc = 0;
    for (int i = 0; i < 264; i++) begin
      cyc(i < 256, 8'(i), 1, 0);
      if (did_pop) begin
        if (first < 0) first = i;
        pops++;
        if (pop_word !== pop_exp) begin
          bad++;
          if (bad < 4) $display("FAIL stream_order got %0h want %0h", pop_word, pop_exp);
        end
      end else if (i >= 3 && i < 259) gaps++;
      if (int'(post_count) > maxc) maxc = int'(post_count);
    end
    checks++; if (bad != 0) errors++;
    checks++; if (first != 3) begin errors++; $display("FAIL stream_lead got %0d want 3", first); end
    checks++; if (pops != 256 || gaps != 0) begin errors++; $display("FAIL stream_rate pops %0d gaps %0d want 256 0", pops, gaps); end
    checks++; if (maxc > 3) begin errors++; $display("FAIL stream_max_count got %0d want <=3", maxc); end
  endtask

  task automatic test_fill();
    int n = 0;
    for (int i = 0; i < 300 && n < 256; i++) begin
      cyc(1, 8'($urandom), 0, 0);
      if (did_push) n++;
    end
    checks++; if (n != 256) begin errors++; $display("FAIL fill_pushes got %0d want 256", n); end
    checks++; if (post_full !== 1'b1 || post_count !== 9'd256) begin errors++; $display("FAIL fill_full full %0b count %0d want 1 256", post_full, post_count); end
    cyc(1, 8'hEE, 0, 0);
    checks++; if (s_ready !== 1'b0 || did_push) begin errors++; $display("FAIL fill_257th in_ready %0b want 0", s_ready); end
    checks++; if (post_count !== 9'd256) begin errors++; $display("FAIL fill_count_hold got %0d want 256", post_count); end
  endtask

  task automatic test_full_pulse();
    int bad = 0, pops = 0;
    cyc(1, 8'h5A, 1, 0);
    checks++; if (!did_pop || did_push) begin errors++; $display("FAIL pulse_pop pop %0b push %0b want 1 0", did_pop, did_push); end
    cyc(1, 8'h5A, 0, 0);
    checks++; if (!did_push || post_count !== 9'd256) begin errors++; $display("FAIL pulse_refill push %0b count %0d want 1 256", did_push, post_count); end
    for (int i = 0; i < 400 && (exp_q.size() > 0 || post_count != 0); i++) begin
      cyc(0, 8'h00, 1, 0);
      if (did_pop) begin
        pops++;
        if (pop_word !== pop_exp) begin
          bad++;
          if (bad < 4) $display("FAIL drain_order got %0h want %0h", pop_word, pop_exp);
        end
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (pops != 256 || post_empty !== 1'b1) begin errors++; $display("FAIL drain_count pops %0d empty %0b want 256 1", pops, post_empty); end
  endtask

  task automatic test_clear();
    int seen = 0;
    for (int i = 0; i < 6; i++) cyc(1, 8'(8'h80 + i), 0, 0);
    repeat (2) cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    checks++; if (pop_word !== pop_exp) begin errors++; $display("FAIL clear_pre_pop got %0h want %0h", pop_word, pop_exp); end
    cyc(1, 8'h99, 0, 1);
    checks++; if (post_count !== 9'd0 || post_valid !== 1'b0 || post_empty !== 1'b1)
      begin errors++; $display("FAIL clear_state count %0d valid %0b empty %0b want 0 0 1", post_count, post_valid, post_empty); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0);
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL clear_stale valid %0b data %0h want 0", s_valid, s_data); end
    end
    cyc(1, 8'h3C, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'h00, 1, 0);
      if (did_pop) begin
        seen++;
        checks++; if (pop_word !== pop_exp) begin errors++; $display("FAIL clear_after got %0h want %0h", pop_word, pop_exp); end
      end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL clear_after_pops got %0d want 1", seen); end
  endtask

  task automatic test_reset_midstream();
    int first = -1;
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 1, 0);
    in_valid = 1; in_data = 8'h77; out_ready = 1;
    RSTN = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid valid %0b ready %0b want 0 0", out_valid, in_ready); end
    exp_q.delete();
    @(posedge CLK); #1;
    RSTN = 1'b1;
    cyc(1, 8'hA5, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 8'h00, 1, 0);
      if (s_valid && first < 0) begin
        first = k;
        checks++; if (s_data !== 8'hA5) begin errors++; $display("FAIL rst_mid_data got %0h want a5", s_data); end
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL rst_mid_latency got %0d want 3", first); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      logic iv, ordy, clr;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 400 < 300) ? ($urandom_range(0, 2) != 0) : 1'b0;
      clr  = ($urandom_range(0, 99) == 0);
      cyc(iv, 8'($urandom), ordy, clr);
      if (did_pop && pop_word !== pop_exp) begin
        bad++; if (bad < 4) $display("FAIL rand_data cyc %0d got %0h want %0h", i, pop_word, pop_exp);
      end
      if (s_ready !== (pre_size < 256 && !clr)) begin
        bad++; if (bad < 4) $display("FAIL rand_in_ready cyc %0d got %0b model size %0d", i, s_ready, pre_size);
      end
      if (int'(post_count) != exp_q.size() || post_full !== (exp_q.size() == 256) || post_empty !== (exp_q.size() == 0)) begin
        bad++; if (bad < 4) $display("FAIL rand_count cyc %0d got %0d want %0d", i, post_count, exp_q.size());
      end
    end
    checks++; if (bad != 0) errors++;
  endtask

  initial begin
    test_reset();
    test_fall_through();
    test_stream();
    test_fill();
    test_full_pulse();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
